// File: rtl/freq_meter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : freq_meter_pkg
//  Description : Shared state encoding and sizing helper for freq_meter.
//  Revision    : 1.0  initial release
// ============================================================================
package freq_meter_pkg;

   // Measurement FSM states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GATE  = 2'd1,
      LATCH = 2'd2
   } state_t;

   // Width of the gate counter; a one-cycle window still needs one bit
   function automatic int gate_cnt_width(input int cycles);
      return (cycles > 1) ? $clog2(cycles) : 1;
   endfunction

endpackage : freq_meter_pkg
`default_nettype wire

// File: rtl/sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : sync_edge
//  Description : Multi-stage synchronizer for an asynchronous input followed
//                by a rising-edge detector (one-cycle pulse per rising edge).
//  Revision    : 1.0  initial release
// ============================================================================
module sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic sig_in,
   output logic edge_pulse
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;

   // Synchronizer chain plus one delayed copy for edge detection
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sync <= '0;
         r_prev <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], sig_in};
         r_prev <= r_sync[SYNC_STAGES-1];
      end
   end

   assign edge_pulse = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule : sync_edge
`default_nettype wire

// File: rtl/freq_meter.sv
`default_nettype none
// ============================================================================
//  Module      : freq_meter
//  Description : Gate-time frequency counter. Counts rising edges of an
//                asynchronous input over GATE_CYCLES clk cycles and latches
//                the (saturating) count as the measured frequency.
//  Revision    : 1.0  initial release
// ============================================================================
module freq_meter
   import freq_meter_pkg::*;
#(
   parameter int GATE_CYCLES = 100_000_000,
   parameter int CNT_W       = 24,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sig_in,
   input  logic             start,
   input  logic             cont,
   output logic             busy,
   output logic [CNT_W-1:0] freq,
   output logic             ovf,
   output logic             done
);

   localparam int                  c_gate_w    = gate_cnt_width(GATE_CYCLES);
   localparam logic [c_gate_w-1:0] c_gate_last = c_gate_w'(GATE_CYCLES - 1);
   localparam logic [c_gate_w-1:0] c_gate_inc  = c_gate_w'(1);
   localparam logic [CNT_W-1:0]    c_cnt_max   = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0]    c_cnt_inc   = CNT_W'(1);

   state_t              r_state;
   state_t              w_next;
   logic [c_gate_w-1:0] r_gate_cnt;
   logic [CNT_W-1:0]    r_edge_cnt;
   logic                r_sat;
   logic                w_edge;
   logic                w_last;

   sync_edge #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync_edge (
      .clk        (clk),
      .rst        (rst),
      .sig_in     (sig_in),
      .edge_pulse (w_edge)
   );

   assign w_last = (r_gate_cnt == c_gate_last);

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= IDLE;
      else      r_state <= w_next;
   end

   // Next-state logic; start and cont are only looked at outside the window
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:    if (start || cont) w_next = GATE;
         GATE:    if (w_last)        w_next = LATCH;
         LATCH:   w_next = cont ? GATE : IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Gate counter and saturating edge counter, cleared whenever not gating
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_gate_cnt <= '0;
         r_edge_cnt <= '0;
         r_sat      <= 1'b0;
      end else if (r_state == GATE) begin
         r_gate_cnt <= r_gate_cnt + c_gate_inc;
         if (w_edge) begin
            if (r_edge_cnt == c_cnt_max) r_sat      <= 1'b1;
            else                         r_edge_cnt <= r_edge_cnt + c_cnt_inc;
         end
      end else begin
         r_gate_cnt <= '0;
         r_edge_cnt <= '0;
         r_sat      <= 1'b0;
      end
   end

   // Registered outputs: result captured in LATCH, done follows one cycle later
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         freq <= '0;
         ovf  <= 1'b0;
         done <= 1'b0;
         busy <= 1'b0;
      end else begin
         done <= (r_state == LATCH);
         busy <= (w_next == GATE) || (w_next == LATCH);
         if (r_state == LATCH) begin
            freq <= r_edge_cnt;
            ovf  <= r_sat;
         end
      end
   end

endmodule : freq_meter
`default_nettype wire

// File: tb/tb_freq_meter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_freq_meter
//  Description : Self-checking bench for freq_meter. Two instances (24-bit and
//                4-bit counters) share stimulus; a window-level model predicts
//                busy/done/freq/ovf every cycle from the recorded input history.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_freq_meter;

   localparam int G     = 1000;
   localparam int MAX_A = (1 << 24) - 1;
   localparam int MAX_B = (1 << 4) - 1;

   logic        clk;
   logic        rst;
   logic        sig_in;
   logic        start;
   logic        cont;
   logic        busy_a, busy_b;
   logic [23:0] freq_a;
   logic [3:0]  freq_b;
   logic        ovf_a, ovf_b;
   logic        done_a, done_b;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   freq_meter #(.GATE_CYCLES(G), .CNT_W(24), .SYNC_STAGES(2)) u_dut_a (
      .clk(clk), .rst(rst), .sig_in(sig_in), .start(start), .cont(cont),
      .busy(busy_a), .freq(freq_a), .ovf(ovf_a), .done(done_a)
   );

   freq_meter #(.GATE_CYCLES(G), .CNT_W(4), .SYNC_STAGES(2)) u_dut_b (
      .clk(clk), .rst(rst), .sig_in(sig_in), .start(start), .cont(cont),
      .busy(busy_b), .freq(freq_b), .ovf(ovf_b), .done(done_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- signal generator ----------------
   // mode 0: constant cval; 1: square wave of period per (low half first); 2: random bits
   int   mode = 2;
   int   per  = 10;
   int   base = 0;
   logic cval = 1'b0;

   initial begin
      sig_in = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (mode)
            0:       sig_in = cval;
            1:       sig_in = (((cyc - base) % per) >= (per / 2));
            default: sig_in = 1'($urandom % 2);
         endcase
      end
   end

   // ---------------- behavioural model ----------------
   // hist[n] is the sig_in level the synchronizer actually sees in cycle n.
   // An edge is counted in cycle m when hist[m-2]=1 and hist[m-3]=0, and a
   // window started (request seen) in cycle s gates cycles s+1 .. s+G.
   bit hist [0:65535];

   function automatic int win_count(input int s);
      int n = 0;
      for (int m = s + 1; m <= s + G; m++)
         if (m >= 3 && hist[m-2] && !hist[m-3]) n++;
      return n;
   endfunction

   bit active  = 0;
   int ws      = 0;
   int done_at = -1;
   int pend_n  = 0;
   int ef_a = 0, ef_b = 0;
   bit eo_a = 0, eo_b = 0;

   always @(negedge clk) begin
      bit exp_busy, exp_done;
      hist[cyc] = rst ? sig_in : 1'b0;
      if (!rst) begin
         active = 0; done_at = -1;
         ef_a = 0; ef_b = 0; eo_a = 0; eo_b = 0;
         exp_busy = 0; exp_done = 0;
      end else begin
         exp_busy = active && (cyc >= ws + 1) && (cyc <= ws + G + 1);
         exp_done = (cyc == done_at);
         if (exp_done) begin
            ef_a = (pend_n > MAX_A) ? MAX_A : pend_n;
            eo_a = (pend_n > MAX_A);
            ef_b = (pend_n > MAX_B) ? MAX_B : pend_n;
            eo_b = (pend_n > MAX_B);
         end
      end
      check("busy_a", busy_a, exp_busy);
      check("done_a", done_a, exp_done);
      check("freq_a", freq_a, ef_a);
      check("ovf_a",  ovf_a,  eo_a);
      check("busy_b", busy_b, exp_busy);
      check("done_b", done_b, exp_done);
      check("freq_b", freq_b, ef_b);
      check("ovf_b",  ovf_b,  eo_b);
      if (rst) begin
         if (!active) begin
            if (start || cont) begin
               active = 1;
               ws     = cyc;
            end
         end else if (cyc == ws + G + 1) begin
            pend_n  = win_count(ws);
            done_at = cyc + 1;
            if (cont) ws = cyc;
            else      active = 0;
         end
      end
   end

   // ---------------- directed helpers ----------------
   task automatic pulse_start(output int s);
      @(posedge clk); #1;
      start = 1'b1;
      s     = cyc;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int limit, output int at);
      at = -1;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (done_a === 1'b1) begin
            at = cyc;
            break;
         end
      end
      if (at < 0) check("done_timeout", 0, 1);
   endtask

   task automatic count_dones(input int ncyc, output int n);
      n = 0;
      for (int i = 0; i < ncyc; i++) begin
         @(negedge clk);
         if (done_a === 1'b1) n++;
      end
   endtask

   task automatic set_square(input int p);
      per  = p;
      base = cyc;
      mode = 1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int s, d, d_prev, n;
      rst = 1'b0; start = 1'b0; cont = 1'b0;

      // Reset held with a toggling input
      repeat (20) @(posedge clk);
      @(negedge clk);
      check("rst_freq", freq_a, 0);
      check("rst_ovf",  ovf_a,  0);
      check("rst_done", done_a, 0);
      check("rst_busy", busy_a, 0);
      @(posedge clk); #1 rst = 1'b1;
      count_dones(30, n);
      check("rst_release_no_done", n, 0);

      // Single shot, period 10
      set_square(10);
      pulse_start(s);
      wait_done(2 * G, d);
      check("sq10_latency", d - s, G + 2);
      check("sq10_freq",    freq_a, 100);
      check("sq10_ovf",     ovf_a,  0);
      check("sq10_freq_b",  freq_b, 15);
      check("sq10_ovf_b",   ovf_b,  1);

      // Constant high, then constant low
      cval = 1'b1; mode = 0;
      repeat (10) @(posedge clk);
      pulse_start(s);
      wait_done(2 * G, d);
      check("hi_latency", d - s, G + 2);
      check("hi_freq",    freq_a, 0);
      check("hi_ovf",     ovf_a,  0);
      cval = 1'b0;
      repeat (10) @(posedge clk);
      pulse_start(s);
      wait_done(2 * G, d);
      check("lo_freq", freq_a, 0);

      // Saturation on the narrow instance, then recovery
      set_square(4);
      pulse_start(s);
      wait_done(2 * G, d);
      check("sq4_freq_a", freq_a, 250);
      check("sq4_freq_b", freq_b, 15);
      check("sq4_ovf_b",  ovf_b,  1);
      set_square(100);
      pulse_start(s);
      wait_done(2 * G, d);
      check("sq100_freq_b", freq_b, 10);
      check("sq100_ovf_b",  ovf_b,  0);

      // Continuous mode, period 20, with ignored start pulses
      set_square(20);
      @(posedge clk); #1 cont = 1'b1;
      wait_done(2 * G, d_prev);
      check("cont_freq0", freq_a, 50);
      for (int k = 0; k < 3; k++) begin
         repeat (300) @(posedge clk);
         #1 start = 1'b1;
         @(posedge clk); #1 start = 1'b0;
         wait_done(2 * G, d);
         check("cont_period", d - d_prev, G + 1);
         check("cont_freq",   freq_a, 50);
         d_prev = d;
      end
      repeat (400) @(posedge clk);
      #1 cont = 1'b0;
      wait_done(2 * G, d);
      check("cont_drop_period", d - d_prev, G + 1);
      check("cont_drop_freq",   freq_a, 50);
      count_dones(G + 100, n);
      check("cont_drop_no_more_done", n, 0);
      check("cont_drop_busy", busy_a, 0);

      // Reset mid-window
      pulse_start(s);
      repeat (499) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("abort_freq", freq_a, 0);
      check("abort_busy", busy_a, 0);
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      count_dones(G + 500, n);
      check("abort_no_done", n, 0);
      check("abort_busy_after", busy_a, 0);

      // Randomized traffic against the model
      for (int i = 0; i < 9000; i++) begin
         @(posedge clk); #1;
         if (i % 500 == 0) begin
            case ($urandom % 3)
               0: set_square(int'($urandom_range(2, 40)));
               1: begin cval = 1'($urandom % 2); mode = 0; end
               default: mode = 2;
            endcase
         end
         start = ($urandom % 40 == 0);
         if ($urandom % 900 == 0) cont = ~cont;
         if (i == 4500) rst = 1'b0;
         if (i == 4506) rst = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      cont  = 1'b0;
      repeat (G + 50) @(posedge clk);
      @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_freq_meter
`default_nettype wire
